// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int WORD_BYTES = 4;

  // An access is illegal when it is misaligned or when its word index is out of range.
  // The index is zero-extended to 32 bits before the compare, so no upper address bit is dropped.
  function automatic logic addr_illegal(input logic [31:0] a, input logic [31:0] depth);
    logic [31:0] word_idx;
    word_idx = {2'b00, a[31:2]};
    return (a[1:0] != 2'b00) || (word_idx >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: combinational read, synchronous write, no reset.
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Commit a store on the rising edge when the write enable is high.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store in IDLE, waits LATENCY cycles,
// then pulses ready for one cycle with the registered response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int          CNT_W   = $clog2(LATENCY + 1);
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          OFF_W   = $clog2(WORD_BYTES);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             accept_s;
  logic             resp_load_s;
  logic             illegal_s;
  logic             mem_we_s;
  logic [31:0]      mem_rdata_s;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we_s),
    .addr_i  (addr_q[AW+OFF_W-1:OFF_W]),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata_s)
  );

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> WAIT on req, WAIT -> RESP when the counter is exhausted, RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/control decode: acceptance, response capture and store commit strobes.
  always_comb begin
    accept_s    = 1'b0;
    resp_load_s = 1'b0;
    mem_we_s    = 1'b0;
    illegal_s   = addr_illegal(addr_q, DEPTH_W);
    case (state_q)
      IDLE: begin
        accept_s = req;
      end
      WAIT: begin
        resp_load_s = (cnt_q == CNT_ZERO);
      end
      RESP: begin
        // The store lands on the edge that ends RESP, so a reset during RESP drops it.
        mem_we_s = we_q & ~illegal_s;
      end
      default: begin
        accept_s    = 1'b0;
        resp_load_s = 1'b0;
        mem_we_s    = 1'b0;
      end
    endcase
  end

  // Wait-state counter: loaded on acceptance, counts down to zero in WAIT and holds there.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_s) begin
      cnt_d = CNT_LOAD;
    end else if ((state_q == WAIT) && (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Response values, registered on the WAIT -> RESP edge and zero everywhere else.
  always_comb begin
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = 32'h0000_0000;
    if (resp_load_s) begin
      ready_d = 1'b1;
      err_d   = illegal_s;
      if (!we_q && !illegal_s) begin
        rdata_d = mem_rdata_s;
      end else begin
        rdata_d = 32'h0000_0000;
      end
    end else begin
      ready_d = 1'b0;
      err_d   = 1'b0;
      rdata_d = 32'h0000_0000;
    end
  end

  // Request latches, counter and registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= CNT_ZERO;
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      if (accept_s) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready = ready_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule
